// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, done pulse WIDTH+1 cycles after start.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow flag (ovf).

module full_adder_s (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder_s u_fa (
    .a_i (shift_a_q[0]),
    .b_i (shift_b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = fa_s;
    end else begin : g_res_wn
      assign res_shift = {fa_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SHIFT) || (state_q == S_DONE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif
    if (state_q == S_IDLE && start) begin
      shift_a_d = a;
      shift_b_d = b;
      carry_d   = cin;
      cnt_d     = '0;
    end else if (state_q == S_SHIFT) begin
      shift_a_d = shift_a_q >> 1;
      shift_b_d = shift_b_q >> 1;
      res_d     = res_shift;
      carry_d   = fa_c;
      cnt_d     = cnt_q + CW'(1);
      // Publish the whole result at once so sum/cout never show partial values.
      if (last_bit) begin
        sum_d  = res_shift;
        cout_d = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d  = carry_q ^ fa_c;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_a_q <= '0;
      shift_b_q <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
